// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl: behavioural main-memory model behind a cache. Accepts whole-line
// read and write commands on a shared tri-state command/data bus and answers
// after a fixed latency.
//
// Ports
//   clk     : single clock, all state changes on the rising edge
//   reset   : synchronous active-high reset (storage is preserved)
//   m_dump  : simulation aid, while high every line is printed on each clk edge
//   addr2   : line address from the cache
//   data2   : 16-bit line data bus (inout), driven here only during read beats
//   ctrl2   : 2-bit command/response bus (inout)
//             0 = NOP, 1 = RESPONSE (from here), 2 = READ_LINE, 3 = WRITE_LINE
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | bus released, sampling ctrl2 for a command
// ST_WR_RECV | collecting beats 1..BEATS-1 of a write line
// ST_WAIT    | latency countdown, bus released, ctrl2 ignored
// ST_RESP_RD | driving ctrl2 = 1 and one data beat per cycle
// ST_RESP_WR | driving ctrl2 = 1 for a single acknowledge cycle
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int LINE_SIZE   = 16,
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_dump,
    input  logic [ADDR_W-1:0] addr2,
    inout  wire  [15:0]       data2,
    inout  wire  [1:0]        ctrl2
);

    localparam int LINE_W = LINE_SIZE * 8;
    localparam int BEATS  = LINE_SIZE / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
    localparam int NLINES = 2 ** ADDR_W;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_TC    = LAT_W'(1);

    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_RECV,
        ST_WAIT,
        ST_RESP_RD,
        ST_RESP_WR
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_is_write;
    logic [LINE_W-1:0]   r_wline;
    logic [LINE_W-1:0]   r_line;
    logic [15:0]         r_data_out;
    logic                r_drive_ctrl;
    logic                r_drive_data;

    logic [LINE_W-1:0]   r_mem [NLINES];

    logic [LINE_W-1:0]   w_wr_line;
    logic                w_commit;

    assign ctrl2 = r_drive_ctrl ? 2'b01      : 2'bzz;
    assign data2 = r_drive_data ? r_data_out : 16'hzzzz;

    // Power-up image: byte k of the flat storage holds k mod 256.
    initial begin
        for (int l = 0; l < NLINES; l++) begin
            for (int j = 0; j < LINE_SIZE; j++) begin
                r_mem[l][8*j +: 8] = 8'((l * LINE_SIZE + j) % 256);
            end
        end
    end

    // The last beat goes straight from the bus into the committed line, so
    // the whole line lands in storage on a single edge.
    always_comb begin
        w_wr_line = r_wline;
        w_wr_line[r_beat_cnt*16 +: 16] = data2;
    end

    assign w_commit = !reset && (r_state == ST_WR_RECV) && (r_beat_cnt == BEAT_LAST);

    always @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_addr] <= w_wr_line;
        end
    end

    always @(posedge clk) begin
        if (m_dump) begin
            for (int l = 0; l < NLINES; l++) begin
                $display("%h: %h", l[ADDR_W-1:0], r_mem[l]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_lat_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_is_write   <= 1'b0;
            r_wline      <= '0;
            r_line       <= '0;
            r_data_out   <= '0;
            r_drive_ctrl <= 1'b0;
            r_drive_data <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Equality on X/Z is not true, so undriven or unknown
                    // ctrl2 simply keeps the block idle.
                    if (ctrl2 == CMD_READ) begin
                        r_addr     <= addr2;
                        r_lat_cnt  <= LAT_LOAD;
                        r_is_write <= 1'b0;
                        r_state    <= ST_WAIT;
                    end else if (ctrl2 == CMD_WRITE) begin
                        r_addr        <= addr2;
                        r_wline[15:0] <= data2;
                        r_beat_cnt    <= BEAT_W'(1);
                        r_state       <= ST_WR_RECV;
                    end
                end

                ST_WR_RECV: begin
                    if (r_beat_cnt == BEAT_LAST) begin
                        r_beat_cnt <= '0;
                        r_lat_cnt  <= LAT_LOAD;
                        r_is_write <= 1'b1;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_wline[r_beat_cnt*16 +: 16] <= data2;
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end

                ST_WAIT: begin
                    // Loaded with MEM_LATENCY on the capture edge; terminal
                    // count of 1 makes the response start exactly MEM_LATENCY
                    // edges after capture.
                    if (r_lat_cnt == LAT_TC) begin
                        r_lat_cnt    <= '0;
                        r_drive_ctrl <= 1'b1;
                        if (r_is_write) begin
                            r_state <= ST_RESP_WR;
                        end else begin
                            r_line       <= r_mem[r_addr];
                            r_data_out   <= r_mem[r_addr][15:0];
                            r_drive_data <= 1'b1;
                            r_beat_cnt   <= BEAT_W'(1);
                            r_state      <= ST_RESP_RD;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_TC;
                    end
                end

                ST_RESP_RD: begin
                    // Counter wraps to zero after the last beat is put on
                    // the bus; seeing zero here means the burst is done.
                    if (r_beat_cnt == '0) begin
                        r_drive_ctrl <= 1'b0;
                        r_drive_data <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_data_out <= r_line[r_beat_cnt*16 +: 16];
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end

                ST_RESP_WR: begin
                    r_drive_ctrl <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_drive_ctrl <= 1'b0;
                    r_drive_data <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int LAT = 100;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        m_dump = 1'b0;
    logic [13:0] addr2  = '0;
    wire  [15:0] data2;
    wire  [1:0]  ctrl2;

    logic        tb_den  = 1'b0;
    logic        tb_cen  = 1'b0;
    logic [15:0] tb_data = '0;
    logic [1:0]  tb_ctrl = '0;

    int n_cmp = 0;
    int n_err = 0;

    assign data2 = tb_den ? tb_data : 16'hzzzz;
    assign ctrl2 = tb_cen ? tb_ctrl : 2'bzz;

    always #5 clk = ~clk;

    mem_ctrl #(
        .LINE_SIZE  (16),
        .ADDR_W     (14),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m_dump(m_dump),
        .addr2 (addr2),
        .data2 (data2),
        .ctrl2 (ctrl2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both DUT bus enables must be off (ctrl2 and data2 released).
    task automatic check_released(input string tag);
        check(tag, {14'd0, dut.r_drive_ctrl, dut.r_drive_data}, 16'd0);
    endtask

    // Watch the bus for n cycles; any DUT drive is a failure.
    task automatic check_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            tick;
            seen = seen | dut.r_drive_ctrl | dut.r_drive_data;
        end
        check(tag, {15'd0, seen}, 16'd0);
    endtask

    task automatic do_read(input logic [13:0] a, input logic [15:0] base,
                           input logic [15:0] step, input bit pulse);
        tb_cen  = 1'b1;
        tb_ctrl = 2'd2;
        addr2   = a;
        tick;                       // capture edge T0
        tb_cen  = 1'b0;
        addr2   = '0;
        for (int c = 1; c < LAT; c++) begin
            if (pulse && c == 40) begin
                tb_cen  = 1'b1;
                tb_ctrl = 2'd2;
                addr2   = 14'd20;
            end else begin
                tb_cen  = 1'b0;
            end
            tick;
        end
        tb_cen = 1'b0;
        check_released("rd_wait");  // edge T0+LAT-1
        for (int i = 0; i < 8; i++) begin
            tick;                   // edge T0+LAT+i
            check("rd_ctrl", {14'd0, ctrl2}, 16'd1);
            check("rd_beat", data2, 16'(base + i * step));
        end
        tick;
        check_released("rd_release");
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] base,
                            input logic [15:0] step);
        tb_cen  = 1'b1;
        tb_ctrl = 2'd3;
        addr2   = a;
        tb_den  = 1'b1;
        tb_data = base;
        tick;                       // beat 0
        tb_cen  = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tb_data = 16'(base + i * step);
            tick;                   // beat i, last at T7
        end
        tb_den = 1'b0;
        for (int c = 1; c < LAT; c++) tick;
        check_released("wr_wait");
        tick;                       // edge T7+LAT
        check("wr_ack", {14'd0, ctrl2}, 16'd1);
        check("wr_ack_nodata", {15'd0, dut.r_drive_data}, 16'd0);
        tick;
        check_released("wr_release");
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick;
        tick;
        check_released("reset");
        reset = 1'b0;
        tick;

        // Read of an untouched line
        do_read(14'd5, 16'h5150, 16'h0202, 1'b0);

        // Write then immediate read-back
        do_write(14'd3, 16'hA000, 16'h0001);
        do_read(14'd3, 16'hA000, 16'h0001, 1'b0);

        // Neighbouring line unaffected by the write
        do_read(14'd4, 16'h4140, 16'h0202, 1'b0);

        // Reset in the middle of a write burst
        tb_cen  = 1'b1;
        tb_ctrl = 2'd3;
        addr2   = 14'd9;
        tb_den  = 1'b1;
        tb_data = 16'hB000;
        tick;
        tb_cen  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tb_data = 16'(16'hB000 + i);
            tick;
        end
        tb_data = 16'hB004;
        reset   = 1'b1;
        tick;
        reset   = 1'b0;
        tb_den  = 1'b0;
        check_released("rst_mid_wr");
        check_quiet("rst_no_ack", LAT + 10);
        do_read(14'd9, 16'h9190, 16'h0202, 1'b0);

        // Read command pulsed during WAIT must be ignored
        do_read(14'd7, 16'h7170, 16'h0202, 1'b1);
        check_quiet("no_second_resp", LAT + 10);

        // Reset during a read response aborts it
        tb_cen  = 1'b1;
        tb_ctrl = 2'd2;
        addr2   = 14'd6;
        tick;
        tb_cen  = 1'b0;
        for (int c = 1; c < LAT + 3; c++) tick;
        check("rsp_before_rst", {14'd0, ctrl2}, 16'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_released("rsp_abort");
        check_quiet("rsp_abort_quiet", 12);

        // Idle noise: ctrl2 alternating RESPONSE and released
        for (int c = 0; c < 50; c++) begin
            tb_cen  = (c % 2 == 0);
            tb_ctrl = 2'd1;
            tick;
            if (c == 49) check_released("idle_noise");
        end
        tb_cen = 1'b0;
        check_quiet("idle_after_noise", 5);
        do_read(14'h3FFF, 16'hF1F0, 16'h0202, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16, meaning cache line size in bytes; one line is LINE_SIZE/2 16-bit beats.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning line-address width; storage is 2^ADDR_W lines.
REQ-003 SHALL have parameter MEM_LATENCY, default 100, meaning cycles from command capture to first response beat; legal values are 2 or more.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port m_dump, input, 1 bit, simulation-only; each rising edge prints every line as hex via $display.
REQ-007 SHALL have port addr2, input, ADDR_W bits, line address driven by the cache.
REQ-008 SHALL have port data2, inout, 16 bits, line data bus; driven only while the internal drive_data enable is 1, else high-Z.
REQ-009 SHALL have port ctrl2, inout, 2 bits, command/response bus; driven only while the internal drive_ctrl enable is 1, else high-Z.

Function
REQ-010 SHALL decode ctrl2 as 0 = NOP, 1 = RESPONSE (driven by this block), 2 = READ_LINE, 3 = WRITE_LINE.
REQ-011 SHALL initialise storage at time 0 so that byte k = k mod 256; beat i of a line = {byte 2i+1, byte 2i}, i.e. line bits [16i+15:16i].
REQ-012 SHALL implement states IDLE, WR_RECV, WAIT, RESP_RD, RESP_WR.
REQ-013 IDLE: SHALL sample ctrl2 each rising edge; 2 -> latch addr2, enter WAIT; 3 -> latch addr2 and data2 as beat 0, enter WR_RECV; 0, 1, X or Z -> stay IDLE.
REQ-014 WR_RECV: SHALL capture data2 as beats 1..LINE_SIZE/2-1 on the next LINE_SIZE/2-1 consecutive rising edges, ignoring ctrl2 value, using a 3-bit beat counter.
REQ-015 SHALL commit the whole write line to storage atomically at the edge capturing the last beat, then enter WAIT.
REQ-016 WAIT: SHALL count down so that, for a READ captured at edge T0, drive_ctrl = 1 with ctrl2 = 1 from edge T0+MEM_LATENCY.
REQ-017 WAIT: for a WRITE whose last beat is captured at edge T7, drive_ctrl = 1 from edge T7+MEM_LATENCY.
REQ-018 WAIT: SHALL keep the bus released and ignore all ctrl2 activity.
REQ-019 RESP_RD: SHALL drive ctrl2 = 1 and data2 = beat i of the latched line during the cycles starting at edges T0+MEM_LATENCY+i, for i = 0..LINE_SIZE/2-1.
REQ-020 RESP_RD: SHALL release both buses at edge T0+MEM_LATENCY+LINE_SIZE/2, then return to IDLE.
REQ-021 RESP_WR: SHALL drive ctrl2 = 1 for exactly one cycle with data2 high-Z, then release and return to IDLE.
REQ-022 SHALL not accept a new command on the edge that releases the bus; the earliest next capture is the following edge.
REQ-023 Read data SHALL reflect every previously committed write, including one committed in the immediately preceding transaction.
REQ-024 Latency counter SHALL be wide enough for MEM_LATENCY without wrap; the beat counter wraps 7 -> 0 only at burst end.

Reset
REQ-025 reset = 1 at a rising edge SHALL force IDLE, drive_ctrl = 0, drive_data = 0 (ctrl2/data2 high-Z), and clear all counters and latched address.
REQ-026 Reset mid-WR_RECV SHALL discard the partial line with no storage change; reset mid-WAIT/RESP SHALL abort the response.
REQ-027 Storage contents SHALL be preserved across reset; reset has priority over any same-edge command.

Verification
REQ-028 READ_LINE addr2 = 5 at edge T0, MEM_LATENCY = 100 -> ctrl2 = 1 from T0+100 for 8 cycles, data2 = 16'h5150, 16'h5352 ... 16'h5F5E, then Z.
REQ-029 WRITE_LINE addr2 = 3, beats 16'hA000..16'hA007, then READ_LINE addr2 = 3 -> single-cycle ctrl2 = 1 write ack at T7+100; read returns 16'hA000..16'hA007 in order.
REQ-030 WRITE_LINE addr2 = 9 with reset asserted at beat 4, then READ_LINE addr2 = 9 -> no ack; read returns the unmodified line 16'h9190 .. 16'h9F9E.
REQ-031 ctrl2 = 2 pulsed during WAIT of a prior READ -> ignored; only one 8-beat response occurs, data of the first address.
REQ-032 ctrl2 Z/X or 1 in IDLE for 50 cycles -> no state change, buses stay high-Z; then READ_LINE addr2 = 14'h3FFF -> beat 0 = 16'hF1F0.
